frac_tick_gen: RTL

- Consumes the quotient/remainder/divisor result of the pipelined unsigned divider and spreads i_divisor evenly spaced one-cycle ticks across an interval of exactly (quotient*divisor + remainder) clock cycles.
- Uses a Bresenham remainder accumulator; used for slot timing inside a measured sync period.

---
 rtl/frac_tick_gen_if.sv | 35 +++
 rtl/frac_tick_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/frac_tick_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : frac_tick_gen_if
//  Description : Request/response bundle of the fractional tick generator.
//                The requester (master) drives the divider result and the
//                start/abort controls; the generator (slave) returns status
//                and tick pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface frac_tick_gen_if #(
  parameter int WIDTH = 16
);
  logic             i_valid;
  logic [WIDTH-1:0] i_quotient;
  logic [WIDTH-1:0] i_remainder;
  logic [WIDTH-1:0] i_divisor;
  logic             i_start;
  logic             i_abort;
  logic             o_busy;
  logic             o_tick;
  logic [WIDTH-1:0] o_tick_idx;
  logic             o_done;
  logic             o_err;

  modport master (
    output i_valid, i_quotient, i_remainder, i_divisor, i_start, i_abort,
    input  o_busy, o_tick, o_tick_idx, o_done, o_err
  );

  modport slave (
    input  i_valid, i_quotient, i_remainder, i_divisor, i_start, i_abort,
    output o_busy, o_tick, o_tick_idx, o_done, o_err
  );
endinterface : frac_tick_gen_if
`default_nettype wire

// File: rtl/frac_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : frac_tick_gen
//  Description : Spreads d evenly spaced one-cycle ticks over exactly
//                q*d + r clock cycles using a Bresenham remainder
//                accumulator. Each interval is q or q+1 cycles long.
//  Revision    : 1.0 - initial release
// ============================================================================
module frac_tick_gen #(
  parameter int WIDTH = 16
) (
  input  wire            clk,
  input  wire            reset_n,
  frac_tick_gen_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH:0] C_CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;           // latched interval base length
  logic [WIDTH-1:0] r_q, r_d;           // latched remainder
  logic [WIDTH-1:0] d_q, d_d;           // latched tick count
  logic [WIDTH-1:0] acc_q, acc_d;       // Bresenham accumulator, always < d
  logic [WIDTH:0]   cnt_q, cnt_d;       // cycles left in current interval
  logic [WIDTH-1:0] idx_q, idx_d;       // ticks issued so far
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] tick_idx_q, tick_idx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] w_src_acc, w_src_q, w_src_r, w_src_d;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_len;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_idx_inc;
  logic             w_start_ok;

  // Next interval length and accumulator; in IDLE it works on the raw inputs
  // with a cleared accumulator so the first interval is ready at acceptance.
  always_comb begin
    w_src_acc = acc_q;
    w_src_q   = q_q;
    w_src_r   = r_q;
    w_src_d   = d_q;
    if (state_q == S_IDLE) begin
      w_src_acc = '0;
      w_src_q   = bus.i_quotient;
      w_src_r   = bus.i_remainder;
      w_src_d   = bus.i_divisor;
    end
    w_sum      = {1'b0, w_src_acc} + {1'b0, w_src_r};
    w_len      = {1'b0, w_src_q};
    w_acc_next = w_sum[WIDTH-1:0];
    if (w_sum >= {1'b0, w_src_d}) begin
      w_len      = {1'b0, w_src_q} + C_CNT_ONE;
      // s < 2d, so the low bits of s-d are exact
      w_acc_next = w_sum[WIDTH-1:0] - w_src_d;
    end
  end

  // Sequencer: acceptance checks, interval countdown, tick/done/abort.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    r_d        = r_q;
    d_d        = d_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    busy_d     = 1'b0;
    tick_d     = 1'b0;
    tick_idx_d = tick_idx_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    w_idx_inc  = idx_q + 1'b1;
    w_start_ok = bus.i_valid && (bus.i_divisor != '0) &&
                 (bus.i_quotient != '0) && (bus.i_remainder < bus.i_divisor);

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          if (w_start_ok) begin
            state_d = S_RUN;
            q_d     = bus.i_quotient;
            r_d     = bus.i_remainder;
            d_d     = bus.i_divisor;
            acc_d   = w_acc_next;
            cnt_d   = w_len;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        busy_d     = 1'b1;
        // First RUN cycle exposes the cleared index of the new sequence
        tick_idx_d = idx_q;
        if (cnt_q == C_CNT_ONE) begin
          tick_d     = 1'b1;
          idx_d      = w_idx_inc;
          tick_idx_d = w_idx_inc;
          if (w_idx_inc == d_q) begin
            // Final tick wins over a simultaneous abort
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Reload on the tick cycle so intervals are back to back
            cnt_d = w_len;
            acc_d = w_acc_next;
            if (bus.i_abort) begin
              state_d = S_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
          if (bus.i_abort) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      q_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      tick_q     <= 1'b0;
      tick_idx_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      r_q        <= r_d;
      d_q        <= d_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      tick_q     <= tick_d;
      tick_idx_q <= tick_idx_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_tick     = tick_q;
  assign bus.o_tick_idx = tick_idx_q;
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;

endmodule : frac_tick_gen
`default_nettype wire
